mux2_sel_arb: RTL and testbench
===============================

MUX2_SEL_ARB -- requirements
Module: mux2_sel_arb

Interface
REQ-001 Parameter: MAX_BURST, default 4, legal range 1..15; the maximum number of consecutive grant cycles before a contested grant is forced to switch.
REQ-002 CK  input  1  clock; all state updates on rising edge; single clock domain.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 RA  input  1  request from source A (drives the downstream MUX2 A input).
REQ-005 RB  input  1  request from source B (drives the downstream MUX2 B input).
REQ-006 S  output  1  registered select to the downstream MUX2; 0 selects A, 1 selects B.
REQ-007 GA  output  1  registered grant to A.
REQ-008 GB  output  1  registered grant to B.
REQ-009 V  output  1  registered valid; V = GA | GB.

Function
REQ-010 The FSM shall have states IDLE, GNT_A and GNT_B; GA=1 only in GNT_A, GB=1 only in GNT_B.
REQ-011 The block shall have a registered LAST pointer (0=A last granted, 1=B) and a 4-bit burst counter CNT.
REQ-012 Latency: a request sampled at edge N shall produce the corresponding grant at the output after edge N (one cycle, registered).
REQ-013 IDLE: RA&RB -> grant the source not indicated by LAST; RA only -> GNT_A; RB only -> GNT_B; neither -> stay in IDLE.
REQ-014 GNT_A: if RA=0 -> GNT_B when RB=1, else IDLE.
REQ-015 GNT_A, RA=1, CNT=MAX_BURST-1, RB=1 -> GNT_B (forced switch).
REQ-016 GNT_A, RA=1, CNT=MAX_BURST-1, RB=0 -> stay in GNT_A, CNT <- 0.
REQ-017 GNT_A: all other cases -> stay, CNT <- CNT+1.
REQ-018 GNT_B shall mirror REQ-014..REQ-017 with A and B swapped.
REQ-019 On every entry into a grant state: CNT <- 0, and LAST <- the granted source.
REQ-020 S = 0 in GNT_A, 1 in GNT_B; in IDLE, S shall hold its previous value, so the mux output does not toggle needlessly.
REQ-021 GA and GB shall never both be 1.
REQ-022 A GNT_A->GNT_B switch shall take exactly one edge with no intervening IDLE cycle; S and the grants change on the same edge.
REQ-023 MAX_BURST=1: on a contested request, the grant shall alternate every cycle.

Reset
REQ-024 RST=1 at a rising edge: state <- IDLE, GA=GB=V=0, S=0, CNT=0, LAST=1 (first tie goes to A).
REQ-025 Reset asserted mid-grant shall override all transitions on that edge; requests held through reset shall be granted one cycle after RST deasserts, per REQ-013.

Configuration
REQ-026 Macro MUX2_ARB_LOCK_EN defined: adds input port LK (1 bit).
REQ-027 With MUX2_ARB_LOCK_EN, in a grant state with LK=1: the forced switch of REQ-015 is suppressed and CNT saturates at MAX_BURST-1.
REQ-028 With MUX2_ARB_LOCK_EN, request drop (REQ-014) still releases the grant regardless of LK.
REQ-029 Macro MUX2_ARB_LOCK_EN undefined: no LK port; behaviour exactly as REQ-010..REQ-025.

Structure
REQ-030 Shared package mux2_arb_pkg shall hold the state encoding (IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10), the CNT width constant (4) and the MAX_BURST default.
REQ-031 The burst counter (clear, increment, saturate, terminal-count flag) shall be a sub-module named mux2_arb_cnt.
REQ-032 The top level shall contain the FSM, the LAST pointer and the output registers.

Verification
REQ-033 RST=1 for 2 cycles, then RA=RB=0 -> S=0, GA=GB=V=0, state IDLE.
REQ-034 After reset, RA=RB=1 simultaneously -> GA=1, S=0 next cycle; after 4 cycles (MAX_BURST=4), GB=1, S=1; alternation continues every 4 cycles.
REQ-035 RA=1 alone for 10 cycles -> GA stays 1 for 10 cycles with no gaps; RA=0 -> V=0 next cycle, and S remains 0.
REQ-036 In GNT_B, RB 1->0 while RA=1 -> GA=1, S=0 on the next edge with no IDLE cycle; drive the MUX2 data inputs to A=1, B=0 and check the MUX2 Z output equals 1.
REQ-037 RST asserted during the 3rd cycle of GNT_B with RA=RB=1 -> outputs reset on that edge; after release, GA=1 (LAST=1).
REQ-038 Build with MUX2_ARB_LOCK_EN, LK=1, RA=RB=1 for 12 cycles -> GA held all 12 cycles; LK=0 -> GB=1 within 1 cycle.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared state encoding and counter constants for the mux2_sel_arb two-way arbiter.
package mux2_arb_pkg;

  localparam int CNT_W         = 4;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } arb_state_t;

  // Terminal count of the burst counter: the last cycle a contested grant may keep.
  function automatic logic [CNT_W-1:0] burst_tc(input int max_burst);
    return CNT_W'(max_burst - 1);
  endfunction

endpackage

// File: rtl/mux2_sel_arb_if.sv
// Request/grant/select bundle between two requesters, the arbiter and the downstream MUX2.
interface mux2_sel_arb_if;

  logic ra;
  logic rb;
  logic s;
  logic ga;
  logic gb;
  logic v;

  modport master (
    output ra,
    output rb,
    input  s,
    input  ga,
    input  gb,
    input  v
  );

  modport slave (
    input  ra,
    input  rb,
    output s,
    output ga,
    output gb,
    output v
  );

endinterface

// File: rtl/mux2_arb_cnt.sv
// Burst counter for mux2_sel_arb: clear, increment, optional saturation and terminal-count flag.
module mux2_arb_cnt
  import mux2_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_sat,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = burst_tc(MAX_BURST);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == TC_VAL);
  assign o_tc = w_tc;

  // Clear wins over increment; with saturation enabled the count parks at the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(i_sat && w_tc)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux2_sel_arb.sv
// Two-source burst-limited arbiter driving a MUX2 select; MUX2_ARB_LOCK_EN adds the i_lk grant-lock input.
module mux2_sel_arb
  import mux2_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
`ifdef MUX2_ARB_LOCK_EN
  input  logic          i_lk,
`endif
  mux2_sel_arb_if.slave io_arb
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic r_last;
  logic r_s;
  logic r_ga;
  logic r_gb;
  logic r_v;

  logic w_ra;
  logic w_rb;
  logic w_tc;
  logic w_lock;
  logic w_cnt_clr;
  logic w_cnt_inc;

  assign w_ra = io_arb.ra;
  assign w_rb = io_arb.rb;

`ifdef MUX2_ARB_LOCK_EN
  assign w_lock = i_lk;
`else
  assign w_lock = 1'b0;
`endif

  mux2_arb_cnt #(
    .MAX_BURST(MAX_BURST)
  ) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .i_sat (w_lock),
    .o_tc  (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ra && w_rb) begin
          w_next = r_last ? GNT_A : GNT_B;
        end else if (w_ra) begin
          w_next = GNT_A;
        end else if (w_rb) begin
          w_next = GNT_B;
        end
      end
      GNT_A: begin
        if (!w_ra) begin
          w_next = w_rb ? GNT_B : IDLE;
        end else if (w_tc && !w_lock) begin
          if (w_rb) begin
            w_next = GNT_B;
          end else begin
            w_cnt_clr = 1'b1;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      GNT_B: begin
        if (!w_rb) begin
          w_next = w_ra ? GNT_A : IDLE;
        end else if (w_tc && !w_lock) begin
          if (w_ra) begin
            w_next = GNT_A;
          end else begin
            w_cnt_clr = 1'b1;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Any fresh grant, including a direct A<->B handover, restarts the burst.
    if ((w_next != r_state) && (w_next != IDLE)) begin
      w_cnt_clr = 1'b1;
      w_cnt_inc = 1'b0;
    end
  end

  // Select and LAST only move on a grant, so the MUX2 output stays put while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
      r_s    <= 1'b0;
      r_ga   <= 1'b0;
      r_gb   <= 1'b0;
      r_v    <= 1'b0;
    end else begin
      r_ga <= (w_next == GNT_A);
      r_gb <= (w_next == GNT_B);
      r_v  <= (w_next == GNT_A) || (w_next == GNT_B);
      if (w_next == GNT_A) begin
        r_s    <= 1'b0;
        r_last <= 1'b0;
      end else if (w_next == GNT_B) begin
        r_s    <= 1'b1;
        r_last <= 1'b1;
      end
    end
  end

  assign io_arb.s  = r_s;
  assign io_arb.ga = r_ga;
  assign io_arb.gb = r_gb;
  assign io_arb.v  = r_v;

endmodule

// File: tb/tb_mux2_sel_arb.sv
// Directed scoreboard bench: main arbiter with MAX_BURST=4, second instance with MAX_BURST=1.
// Lock steps are compiled in only when MUX2_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_mux2_sel_arb;

  // {ga,gb,s,v} patterns for the main arbiter and {ga,gb} for the MAX_BURST=1 arbiter.
  localparam logic [3:0] E_IDLE0 = 4'b0000;
  localparam logic [3:0] E_IDLE1 = 4'b0010;
  localparam logic [3:0] E_A     = 4'b1001;
  localparam logic [3:0] E_B     = 4'b0111;
  localparam logic [1:0] ALT_NONE = 2'b00;
  localparam logic [1:0] ALT_A    = 2'b10;
  localparam logic [1:0] ALT_B    = 2'b01;

  typedef struct {
    int         id;
    logic [3:0] mainVec;
    logic [1:0] altVec;
  } expect_t;

  logic clk = 1'b0;
  logic rst;
  logic muxA;
  logic muxB;
  logic muxZ;
  int   total = 0;
  int   bad = 0;
  int   stepId = 0;
  expect_t sbQ[$];

`ifdef MUX2_ARB_LOCK_EN
  logic lk;
`endif

  mux2_sel_arb_if busMain ();
  mux2_sel_arb_if busAlt ();

  always #5 clk = ~clk;

  assign muxZ = busMain.s ? muxB : muxA;

  mux2_sel_arb #(
    .MAX_BURST(4)
  ) dutMain (
    .i_clk  (clk),
    .i_rst  (rst),
`ifdef MUX2_ARB_LOCK_EN
    .i_lk   (lk),
`endif
    .io_arb (busMain.slave)
  );

  mux2_sel_arb #(
    .MAX_BURST(1)
  ) dutAlt (
    .i_clk  (clk),
    .i_rst  (rst),
`ifdef MUX2_ARB_LOCK_EN
    .i_lk   (lk),
`endif
    .io_arb (busAlt.slave)
  );

  task automatic checkOutput();
    expect_t    e;
    logic [3:0] obs;
    logic [1:0] obsAlt;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e      = sbQ.pop_front();
    obs    = {busMain.ga, busMain.gb, busMain.s, busMain.v};
    obsAlt = {busAlt.ga, busAlt.gb};
    total++;
    assert (obs === e.mainVec) else begin
      bad++;
      $error("[TB] FAIL main_step%0d {ga,gb,s,v} observed=%b expected=%b", e.id, obs, e.mainVec);
    end
    total++;
    assert (obsAlt === e.altVec) else begin
      bad++;
      $error("[TB] FAIL alt_step%0d {ga,gb} observed=%b expected=%b", e.id, obsAlt, e.altVec);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb, input logic raAlt,
                               input logic rbAlt, input logic rstIn,
                               input logic [3:0] expMain, input logic [1:0] expAlt);
    expect_t e;
    busMain.ra = ra;
    busMain.rb = rb;
    busAlt.ra  = raAlt;
    busAlt.rb  = rbAlt;
    rst        = rstIn;
    stepId++;
    e.id      = stepId;
    e.mainVec = expMain;
    e.altVec  = expAlt;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    muxA = 1'b1;
    muxB = 1'b0;
    rst  = 1'b1;
    busMain.ra = 1'b0;
    busMain.rb = 1'b0;
    busAlt.ra  = 1'b0;
    busAlt.rb  = 1'b0;
`ifdef MUX2_ARB_LOCK_EN
    lk = 1'b0;
`endif
    $display("[TB] start");

    // Two reset cycles, then idle with no requests.
    applyStimulus(0, 0, 0, 0, 1, E_IDLE0, ALT_NONE);
    applyStimulus(0, 0, 0, 0, 1, E_IDLE0, ALT_NONE);
    applyStimulus(0, 0, 0, 0, 0, E_IDLE0, ALT_NONE);

    // Contested: A first (LAST=1 after reset), then swap every 4 grant cycles.
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1, 1, 0, 0, 0, (((k - 1) / 4) % 2 == 0) ? E_A : E_B, ALT_NONE);
    end
    applyStimulus(0, 0, 0, 0, 0, E_IDLE1, ALT_NONE);

    // A alone for 10 cycles: no gaps, then release with S held at 0.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, 0, 0, 0, E_A, ALT_NONE);
    end
    applyStimulus(0, 0, 0, 0, 0, E_IDLE0, ALT_NONE);

    // B drops while A requests: direct handover to A, MUX2 passes A's data.
    applyStimulus(0, 1, 0, 0, 0, E_B, ALT_NONE);
    applyStimulus(1, 1, 0, 0, 0, E_B, ALT_NONE);
    applyStimulus(1, 0, 0, 0, 0, E_A, ALT_NONE);
    total++;
    assert (muxZ === 1'b1) else begin
      bad++;
      $error("[TB] FAIL mux_z observed=%b expected=1", muxZ);
    end
    applyStimulus(0, 0, 0, 0, 0, E_IDLE0, ALT_NONE);

    // LAST=0 now, so a tie goes to B; reset on its 3rd cycle, then A wins the tie.
    applyStimulus(1, 1, 0, 0, 0, E_B, ALT_NONE);
    applyStimulus(1, 1, 0, 0, 0, E_B, ALT_NONE);
    applyStimulus(1, 1, 0, 0, 1, E_IDLE0, ALT_NONE);
    applyStimulus(1, 1, 0, 0, 0, E_A, ALT_NONE);
    applyStimulus(0, 0, 0, 0, 0, E_IDLE0, ALT_NONE);

    // MAX_BURST=1 instance alternates every cycle when contested, holds when alone.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 1, 1, 0, E_IDLE0, (k % 2 == 1) ? ALT_A : ALT_B);
    end
    applyStimulus(0, 0, 1, 0, 0, E_IDLE0, ALT_A);
    applyStimulus(0, 0, 1, 0, 0, E_IDLE0, ALT_A);
    applyStimulus(0, 0, 0, 0, 0, E_IDLE0, ALT_NONE);

`ifdef MUX2_ARB_LOCK_EN
    // Lock holds A through 12 contested cycles; unlocking hands over on the next edge.
    lk = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, E_A, ALT_NONE);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 1, 0, 0, 0, E_A, ALT_NONE);
    end
    lk = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, E_B, ALT_NONE);
    lk = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, E_A, ALT_NONE);
    lk = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, E_IDLE0, ALT_NONE);
`endif

    total++;
    assert (sbQ.size() == 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
